// File: rtl/truth_table_tester.sv
// truth_table_tester: sweeps all input vectors of a small combinational
// block, samples its output and compares it against an expected table.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         start request, honoured when not busy
//   vec_out       stimulus to the lab block (MSB = first input)
//   dut_in        lab block output
//   busy          sweep in progress
//   done          sweep finished (level, until next start)
//   pass          valid with done; 1 iff no mismatches
//   err_cnt       number of mismatching vectors
//   captured      sampled truth table, bit i = vector i
//   first_fail    first mismatching vector (0 if none)
//
// Build option: define TT_STOP_ON_FAIL_EN to end the sweep at the
// first mismatch instead of running every vector.
module truth_table_tester #(
  parameter int                  N_IN   = 3,
  parameter logic [2**N_IN-1:0]  EXPECT = 8'hE8,
  parameter int                  SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_IN-1:0]     vec_out,
  input  logic                dut_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_cnt,
  output logic [2**N_IN-1:0]  captured,
  output logic [N_IN-1:0]     first_fail
);

  localparam logic [N_IN-1:0] LAST    = {N_IN{1'b1}};
  localparam logic [3:0]      CNT_TOP = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                seen_q;
  logic [N_IN-1:0]     vec_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [N_IN:0]       err_q;
  logic [2**N_IN-1:0]  cap_q;
  logic [N_IN-1:0]     ff_q;

  logic                miss;
  logic [N_IN:0]       err_d;
  logic                end_d;

  assign miss  = (dut_in != EXPECT[vec_q]);
  assign err_d = miss ? err_q + (N_IN+1)'(1) : err_q;

`ifdef TT_STOP_ON_FAIL_EN
  assign end_d = miss || (vec_q == LAST);
`else
  assign end_d = (vec_q == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      cap_q   <= '0;
      ff_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= DRIVE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            cap_q   <= '0;
            ff_q    <= '0;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_TOP) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          cap_q[vec_q] <= dut_in;
          err_q        <= err_d;
          if (miss && !seen_q) begin
            seen_q <= 1'b1;
            ff_q   <= vec_q;
          end
          if (end_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // err_d already includes this final sample
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_q + N_IN'(1);
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign captured   = cap_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_tester.sv
// tb_truth_table_tester: drives sweeps against a modelled lab block
// and checks results against an expected-result queue.
module tb_truth_table_tester;

  localparam int         N_IN   = 3;
  localparam int         NV     = 8;
  localparam int         SETTLE = 2;
  localparam logic [7:0] EXP    = 8'hE8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] vec_out;
  logic       dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] captured;
  logic [2:0] first_fail;

  int mode;
  int n_cmp;
  int n_bad;

  typedef struct {
    logic [7:0] cap;
    logic [3:0] err;
    logic [2:0] ff;
    logic       pass;
    logic [2:0] vec;
    int         lat;
  } res_t;

  res_t       exp_q[$];
  logic [2:0] vec_q[$];

  truth_table_tester #(
    .N_IN  (N_IN),
    .EXPECT(EXP),
    .SETTLE(SETTLE)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_out   (vec_out),
    .dut_in    (dut_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .captured  (captured),
    .first_fail(first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  // mode 0: correct majority block, mode 1: stuck-at-0 block
  always_comb begin
    dut_in = 1'b0;
    if (mode == 0) dut_in = maj(vec_out);
  end

  function automatic res_t model(input int m);
    res_t       r;
    logic       d;
    logic       seen;
    logic       stop;
    logic [2:0] vv;
    r.cap = '0;
    r.err = '0;
    r.ff  = '0;
    r.vec = '0;
    seen  = 1'b0;
    stop  = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (!stop) begin
        vv = v[2:0];
        d = (m == 0) ? maj(vv) : 1'b0;
        r.cap[v] = d;
        r.vec = vv;
        if (d != EXP[v]) begin
          r.err = r.err + 4'd1;
          if (!seen) begin
            seen = 1'b1;
            r.ff = vv;
          end
`ifdef TT_STOP_ON_FAIL_EN
          stop = 1'b1;
`endif
        end
      end
    end
    r.pass = (r.err == 4'd0);
    r.lat  = (int'(r.vec) + 1) * (SETTLE + 1);
    return r;
  endfunction

  task automatic run_sweep(input int m, input bit repulse);
    res_t       e;
    res_t       g;
    logic [2:0] ev;
    logic [7:0] cap_hold;
    int         k;
    mode = m;
    e = model(m);
    exp_q.push_back(e);
    for (int i = 0; i < e.lat; i++)
      vec_q.push_back(3'(i / (SETTLE + 1)));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== 4'd0 ||
        captured !== 8'h00 || first_fail !== 3'd0 || pass !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_clear: busy=%b done=%b err=%0d cap=%h ff=%0d pass=%b want 1 0 0 00 0 0",
               busy, done, err_cnt, captured, first_fail, pass);
    end
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      n_cmp++;
      if (vec_q.size() > 0) begin
        ev = vec_q.pop_front();
        if (vec_out !== ev) begin
          n_bad++;
          $display("FAIL vec_step k=%0d: got %0d want %0d", k, vec_out, ev);
        end
      end else begin
        n_bad++;
        $display("FAIL vec_extra k=%0d: got %0d want done", k, vec_out);
      end
      start = repulse && (k == 7 || k == 19);
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    if (vec_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL early_done: got %0d vectors left want 0", vec_q.size());
      vec_q.delete();
    end
    g = exp_q.pop_front();
    n_cmp++;
    if (k != g.lat) begin
      n_bad++;
      $display("FAIL latency: got %0d want %0d", k, g.lat);
    end
    n_cmp++;
    if (captured !== g.cap) begin
      n_bad++;
      $display("FAIL captured: got %h want %h", captured, g.cap);
    end
    n_cmp++;
    if (err_cnt !== g.err) begin
      n_bad++;
      $display("FAIL err_cnt: got %0d want %0d", err_cnt, g.err);
    end
    n_cmp++;
    if (first_fail !== g.ff) begin
      n_bad++;
      $display("FAIL first_fail: got %0d want %0d", first_fail, g.ff);
    end
    n_cmp++;
    if (pass !== g.pass) begin
      n_bad++;
      $display("FAIL pass: got %b want %b", pass, g.pass);
    end
    n_cmp++;
    if (vec_out !== g.vec || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL end_vec: vec=%0d busy=%b want %0d 0", vec_out, busy, g.vec);
    end
    cap_hold = captured;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || captured !== cap_hold) begin
      n_bad++;
      $display("FAIL done_hold: done=%b busy=%b cap=%h want 1 0 %h",
               done, busy, captured, cap_hold);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (vec_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || err_cnt !== 4'd0 || captured !== 8'h00 ||
        first_fail !== 3'd0) begin
      n_bad++;
      $display("FAIL %s: vec=%0d busy=%b done=%b pass=%b err=%0d cap=%h ff=%0d want all 0",
               tag, vec_out, busy, done, pass, err_cnt, captured, first_fail);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    #3;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_full_pass();
    run_sweep(0, 1'b0);
  endtask

  task automatic test_stuck0();
    run_sweep(1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (vec_out !== 3'd5 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (vec_out !== 3'd5 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reach_vec5: vec=%0d busy=%b want 5 1", vec_out, busy);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle_after_mid_reset");
    run_sweep(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep(0, 1'b1);
    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(1, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    test_reset();
    test_full_pass();
    test_stuck0();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
